// File: rtl/log_seq_ctrl_if.sv
// Request/result bundle for the sequential natural-log controller.
// Master issues start/inp1 and observes busy/done and the result fields.
interface log_seq_ctrl_if;
  logic        start;
  logic [15:0] inp1;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] log_e;
  logic [15:0] log_e_deci;

  modport master (output start, inp1, input busy, done, err, log_e, log_e_deci);
  modport slave  (input start, inp1, output busy, done, err, log_e, log_e_deci);
endinterface

// File: rtl/log_seq_ctrl.sv
// ln(x) via range reduction + atanh series on one shared divider and multiplier.
// Latency FRAC+4+N_TERMS*(FRAC+2) cycles from the start cycle (1 for x=0); start ignored while busy.
module log_seq_ctrl #(
  parameter int FRAC    = 24,
  parameter int N_TERMS = 6,
  parameter int LN2_Q   = 11629080
) (
  input  logic           clk,
  input  logic           rst_n,
  log_seq_ctrl_if.slave  io
);

  localparam int RW = FRAC + 5;
  localparam int CW = $clog2(FRAC + 1);
  localparam int KW = $clog2(N_TERMS + 1);
  localparam int AW = FRAC + 3;
  localparam logic [RW-1:0] ONE_Q = RW'(1) << FRAC;

  typedef enum logic [3:0] {
    S_IDLE, S_NORM, S_DIV_T, S_SQ, S_TERM, S_DIV, S_ACC, S_CONV, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     x_q, x_d;
  logic [3:0]      e_q, e_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   dvs_q, dvs_d;
  logic [FRAC-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FRAC-1:0] t_q, t_d;
  logic [FRAC-1:0] t2_q, t2_d;
  logic [FRAC-1:0] p_q, p_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            err_q, err_d;
  logic [15:0]     log_e_q, log_e_d;
  logic [15:0]     deci_q, deci_d;

  logic [3:0]        lead_e;
  logic [FRAC:0]     m_val;
  logic              div_ge;
  logic [RW-1:0]     rem_nx;
  logic [FRAC-1:0]   quo_nx;
  logic [FRAC-1:0]   mul_a, mul_b;
  logic [2*FRAC-1:0] prod;
  logic [RW-1:0]     r_val;
  logic              mul_lo_unused;

  always_comb begin
    lead_e = '0;
    for (int i = 0; i < 16; i++) begin
      if (x_q[i]) lead_e = 4'(i);
    end
  end

  // Mantissa in [1,2): shifting left by FRAC first keeps the reduction exact.
  assign m_val = (FRAC+1)'({x_q, {FRAC{1'b0}}} >> lead_e);

  // Restoring divider step: one quotient bit per cycle.
  assign div_ge = {rem_q, 1'b0} >= {1'b0, dvs_q};
  assign rem_nx = div_ge ? RW'({rem_q, 1'b0} - {1'b0, dvs_q}) : RW'({rem_q, 1'b0});
  assign quo_nx = {quo_q[FRAC-2:0], div_ge};

  assign r_val = RW'(e_q) * RW'(LN2_Q) + RW'({acc_q, 1'b0});

  always_comb begin
    mul_a = p_q;
    mul_b = t2_q;
    case (state_q)
      S_SQ: begin
        mul_a = t_q;
        mul_b = t_q;
      end
      S_CONV: begin
        mul_a = r_val[FRAC-1:0];
        mul_b = FRAC'(10000);
      end
      default: ;
    endcase
  end

  assign prod          = {{FRAC{1'b0}}, mul_a} * {{FRAC{1'b0}}, mul_b};
  assign mul_lo_unused = ^prod[FRAC-1:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    e_d     = e_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    t2_d    = t2_q;
    p_d     = p_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;
    log_e_d = log_e_q;
    deci_d  = deci_q;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          err_d = 1'b0;
          if (io.inp1 == 16'd0) begin
            err_d   = 1'b1;
            log_e_d = '0;
            deci_d  = '0;
            state_d = S_DONE;
          end else begin
            x_d     = io.inp1;
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        e_d     = lead_e;
        rem_d   = RW'(m_val) - ONE_Q;
        dvs_d   = RW'(m_val) + ONE_Q;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV_T;
      end
      S_DIV_T: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FRAC - 1)) begin
          t_d     = quo_nx;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        t2_d    = prod[2*FRAC-1:FRAC];
        p_d     = t_q;
        k_d     = '0;
        acc_d   = '0;
        state_d = S_TERM;
      end
      S_TERM: begin
        rem_d   = RW'(p_q);
        dvs_d   = RW'({k_q, 1'b1}) << FRAC;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FRAC - 1)) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d   = acc_q + AW'(quo_q);
        p_d     = prod[2*FRAC-1:FRAC];
        k_d     = k_q + 1'b1;
        state_d = (k_q == KW'(N_TERMS - 1)) ? S_CONV : S_TERM;
      end
      S_CONV: begin
        log_e_d = 16'(r_val >> FRAC);
        deci_d  = 16'(prod >> FRAC);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      e_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      t2_q    <= '0;
      p_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      log_e_q <= '0;
      deci_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      e_q     <= e_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      t2_q    <= t2_d;
      p_q     <= p_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      log_e_q <= log_e_d;
      deci_q  <= deci_d;
    end
  end

  assign io.busy       = (state_q != S_IDLE);
  assign io.done       = (state_q == S_DONE);
  assign io.err        = err_q;
  assign io.log_e      = log_e_q;
  assign io.log_e_deci = deci_q;

endmodule

// File: tb/tb_log_seq_ctrl.sv
// Bench for log_seq_ctrl: directed vector table, multi-cycle corner sequences,
// and random operands checked against a real-valued ln() reference.
module tb_log_seq_ctrl;

  localparam int LAT = 184;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  log_seq_ctrl_if sif ();
  log_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .io(sif));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] x;
    int          lat;
    int          err;
    int          log_e;
    int          deci;
    int          tol;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d+-%0d", name, act, exp, tol);
    end
  endtask

  // One operation; counts cycles from the start cycle to the done cycle.
  task automatic do_op(input logic [15:0] x, input int glitch_k, input logic [15:0] glitch_x,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    sif.start = 1'b1;
    sif.inp1  = x;
    lat       = -1;
    busy_cnt  = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (sif.busy) busy_cnt++;
      if (sif.done) begin
        lat = k;
        break;
      end
      sif.start = (k == glitch_k);
      sif.inp1  = (k == glitch_k) ? glitch_x : 16'($urandom);
    end
    sif.start = 1'b0;
  endtask

  initial begin
    int lat, bc, seen, k1, k2, nd, exp_total;
    logic [15:0] x;

    tbl[0] = '{x:16'd1,     lat:LAT, err:0, log_e:0,  deci:0,    tol:0};
    tbl[1] = '{x:16'd2,     lat:LAT, err:0, log_e:0,  deci:6931, tol:1};
    tbl[2] = '{x:16'd10,    lat:LAT, err:0, log_e:2,  deci:3025, tol:1};
    tbl[3] = '{x:16'd65535, lat:LAT, err:0, log_e:11, deci:903,  tol:1};
    tbl[4] = '{x:16'd0,     lat:1,   err:1, log_e:0,  deci:0,    tol:0};
    tbl[5] = '{x:16'd3,     lat:LAT, err:0, log_e:1,  deci:986,  tol:1};
    tbl[6] = '{x:16'd100,   lat:LAT, err:0, log_e:4,  deci:6051, tol:1};

    sif.start = 1'b0;
    sif.inp1  = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_err", sif.err, 0);
    chk("rst_log_e", sif.log_e, 0);
    chk("rst_deci", sif.log_e_deci, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].x, 0, 16'd0, lat, bc);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_busy", i), bc, tbl[i].lat);
      chk($sformatf("tbl%0d_err", i), sif.err, tbl[i].err);
      chk($sformatf("tbl%0d_log_e", i), sif.log_e, tbl[i].log_e);
      chk_near($sformatf("tbl%0d_deci", i), sif.log_e_deci, tbl[i].deci, tbl[i].tol);
    end

    // start pulse while busy must be dropped, not queued
    do_op(16'd10, 50, 16'd3, lat, bc);
    chk("glitch_lat", lat, LAT);
    chk("glitch_log_e", sif.log_e, 2);
    chk_near("glitch_deci", sif.log_e_deci, 3025, 1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (sif.busy || sif.done) seen++;
    end
    chk("glitch_not_queued", seen, 0);

    // start held high: next op accepted in the IDLE cycle after DONE
    @(negedge clk);
    sif.start = 1'b1;
    sif.inp1  = 16'd3;
    nd = 0; k1 = -1; k2 = -1;
    for (int k = 1; k <= 800 && nd < 2; k++) begin
      @(negedge clk);
      if (sif.done) begin
        nd++;
        if (nd == 1) k1 = k; else k2 = k;
        chk($sformatf("b2b%0d_log_e", nd), sif.log_e, 1);
        chk_near($sformatf("b2b%0d_deci", nd), sif.log_e_deci, 986, 1);
      end
    end
    sif.start = 1'b0;
    chk("b2b_first_lat", k1, LAT);
    chk("b2b_gap", k2 - k1, LAT + 1);

    // reset mid-operation aborts with no done
    @(negedge clk);
    @(negedge clk);
    sif.start = 1'b1;
    sif.inp1  = 16'd100;
    seen = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.done) seen++;
    end
    chk("abort_busy_before", sif.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", sif.busy, 0);
    chk("abort_done", sif.done, 0);
    chk("abort_err", sif.err, 0);
    chk("abort_log_e", sif.log_e, 0);
    chk("abort_deci", sif.log_e_deci, 0);
    repeat (3) begin
      @(negedge clk);
      if (sif.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    rst_n = 1'b1;
    do_op(16'd100, 0, 16'd0, lat, bc);
    chk("after_rst_lat", lat, LAT);
    chk("after_rst_log_e", sif.log_e, 4);
    chk_near("after_rst_deci", sif.log_e_deci, 6051, 1);

    // random operands against real-valued ln()
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0:       x = 16'd0;
        1:       x = 16'(1) << $urandom_range(0, 15);
        2:       x = 16'($urandom_range(1, 20));
        default: x = 16'($urandom_range(1, 65535));
      endcase
      do_op(x, 0, 16'd0, lat, bc);
      if (x == 16'd0) begin
        chk($sformatf("rnd%0d_lat x=0", n), lat, 1);
        chk($sformatf("rnd%0d_err x=0", n), sif.err, 1);
        chk($sformatf("rnd%0d_val x=0", n), sif.log_e * 10000 + sif.log_e_deci, 0);
      end else begin
        exp_total = int'($floor($ln(real'(x)) * 10000.0));
        chk($sformatf("rnd%0d_lat x=%0d", n, x), lat, LAT);
        chk($sformatf("rnd%0d_err x=%0d", n, x), sif.err, 0);
        chk_near($sformatf("rnd%0d_val x=%0d", n, x),
                 sif.log_e * 10000 + sif.log_e_deci, exp_total, 1);
        chk_near($sformatf("rnd%0d_deci_range x=%0d", n, x), sif.log_e_deci, 4999, 5000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
